// File: rtl/mips_cpu_bus.sv
`default_nettype none
// ============================================================================
// Module   : mips_cpu_bus
// Purpose  : Multi-cycle MIPS32 subset CPU. A single Avalon-style bus is
//            shared by instruction fetch and data access. The CPU runs from
//            0xBFC00000 until it jumps to address 0, then halts.
// Revision : 1.0  initial release
// ============================================================================
module mips_cpu_bus (
  input  logic        clk,
  input  logic        reset,
  output logic        active,
  output logic [31:0] register_v0,
  output logic [31:0] address,
  output logic        write,
  output logic        read,
  input  logic        waitrequest,
  output logic [31:0] writedata,
  output logic [3:0]  byteenable,
  input  logic [31:0] readdata,
  output logic [31:0] check,
  output logic [2:0]  state_c
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd7
  } state_t;

  localparam logic [31:0] c_RESET_VEC = 32'hBFC0_0000;

  localparam logic [5:0] c_OP_RTYPE = 6'h00;
  localparam logic [5:0] c_OP_J     = 6'h02;
  localparam logic [5:0] c_OP_BEQ   = 6'h04;
  localparam logic [5:0] c_OP_BNE   = 6'h05;
  localparam logic [5:0] c_OP_ADDIU = 6'h09;
  localparam logic [5:0] c_OP_ANDI  = 6'h0C;
  localparam logic [5:0] c_OP_ORI   = 6'h0D;
  localparam logic [5:0] c_OP_XORI  = 6'h0E;
  localparam logic [5:0] c_OP_LUI   = 6'h0F;
  localparam logic [5:0] c_OP_LW    = 6'h23;
  localparam logic [5:0] c_OP_SW    = 6'h2B;

  localparam logic [5:0] c_FN_SLL  = 6'h00;
  localparam logic [5:0] c_FN_SRL  = 6'h02;
  localparam logic [5:0] c_FN_JR   = 6'h08;
  localparam logic [5:0] c_FN_ADDU = 6'h21;
  localparam logic [5:0] c_FN_SUBU = 6'h23;
  localparam logic [5:0] c_FN_AND  = 6'h24;
  localparam logic [5:0] c_FN_OR   = 6'h25;
  localparam logic [5:0] c_FN_XOR  = 6'h26;
  localparam logic [5:0] c_FN_SLT  = 6'h2A;
  localparam logic [5:0] c_FN_SLTU = 6'h2B;

  state_t      r_state, w_next_state;
  logic [31:0] r_pc, r_pc_next, r_ir, r_a, r_b, r_alu, r_target;
  logic [31:0] r_gpr [0:31];
  logic [4:0]  r_dst;
  logic        r_wen, r_taken;
  // Cleared by reset so no request is raised on the reset edge itself.
  logic        r_bus_en;

  logic [5:0]  w_op, w_funct;
  logic [4:0]  w_rs, w_rt, w_rd, w_shamt;
  logic [31:0] w_simm, w_zimm, w_alu, w_target;
  logic [4:0]  w_dst;
  logic        w_wen, w_taken, w_is_lw, w_is_sw;

  assign w_op    = r_ir[31:26];
  assign w_rs    = r_ir[25:21];
  assign w_rt    = r_ir[20:16];
  assign w_rd    = r_ir[15:11];
  assign w_shamt = r_ir[10:6];
  assign w_funct = r_ir[5:0];
  assign w_simm  = {{16{r_ir[15]}}, r_ir[15:0]};
  assign w_zimm  = {16'h0000, r_ir[15:0]};
  assign w_is_lw = (w_op == c_OP_LW);
  assign w_is_sw = (w_op == c_OP_SW);

  // Bus requests are pure functions of state so they hold steady while stalled.
  assign read       = r_bus_en && (((r_state == S_FETCH) && (r_pc != 32'h0)) ||
                                   ((r_state == S_MEM) && w_is_lw));
  assign write      = r_bus_en && (r_state == S_MEM) && w_is_sw;
  assign address    = (r_state == S_MEM) ? r_alu : r_pc;
  assign writedata  = r_b;
  assign byteenable = (read || write) ? 4'b1111 : 4'b0000;
  assign active     = (r_state != S_HALT);
  assign register_v0 = r_gpr[2];
  assign check      = r_ir;
  assign state_c    = r_state;

  // ALU, branch/jump resolution and destination select for the held IR.
  always_comb begin
    w_alu    = 32'h0;
    w_wen    = 1'b0;
    w_dst    = w_rt;
    w_taken  = 1'b0;
    w_target = r_pc_next + {w_simm[29:0], 2'b00};
    case (w_op)
      c_OP_RTYPE: begin
        w_dst = w_rd;
        w_wen = 1'b1;
        case (w_funct)
          c_FN_ADDU: w_alu = r_a + r_b;
          c_FN_SUBU: w_alu = r_a - r_b;
          c_FN_AND:  w_alu = r_a & r_b;
          c_FN_OR:   w_alu = r_a | r_b;
          c_FN_XOR:  w_alu = r_a ^ r_b;
          c_FN_SLT:  w_alu = {31'h0, $signed(r_a) < $signed(r_b)};
          c_FN_SLTU: w_alu = {31'h0, r_a < r_b};
          c_FN_SLL:  w_alu = r_b << w_shamt;
          c_FN_SRL:  w_alu = r_b >> w_shamt;
          c_FN_JR: begin
            w_wen    = 1'b0;
            w_taken  = 1'b1;
            w_target = r_a;
          end
          default:   w_wen = 1'b0;
        endcase
      end
      c_OP_ADDIU: begin w_alu = r_a + w_simm;             w_wen = 1'b1; end
      c_OP_ANDI:  begin w_alu = r_a & w_zimm;             w_wen = 1'b1; end
      c_OP_ORI:   begin w_alu = r_a | w_zimm;             w_wen = 1'b1; end
      c_OP_XORI:  begin w_alu = r_a ^ w_zimm;             w_wen = 1'b1; end
      c_OP_LUI:   begin w_alu = {r_ir[15:0], 16'h0000};   w_wen = 1'b1; end
      c_OP_LW:    begin w_alu = r_a + w_simm;             w_wen = 1'b1; end
      c_OP_SW:    w_alu   = r_a + w_simm;
      c_OP_BEQ:   w_taken = (r_a == r_b);
      c_OP_BNE:   w_taken = (r_a != r_b);
      c_OP_J: begin
        w_taken  = 1'b1;
        w_target = {r_pc_next[31:28], r_ir[25:0], 2'b00};
      end
      default: ;
    endcase
  end

  // Next-state logic; bus phases advance only when the slave stops stalling.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_FETCH: begin
        if (r_pc == 32'h0)              w_next_state = S_HALT;
        else if (read && !waitrequest)  w_next_state = S_DECODE;
      end
      S_DECODE: w_next_state = S_EXEC;
      S_EXEC:   w_next_state = (w_is_lw || w_is_sw) ? S_MEM : S_WB;
      S_MEM:    if (!waitrequest) w_next_state = S_WB;
      S_WB:     w_next_state = S_FETCH;
      S_HALT:   w_next_state = S_HALT;
      default:  w_next_state = S_FETCH;
    endcase
  end

  // State register; reset overrides every state including a stalled request.
  always_ff @(posedge clk) begin
    if (!reset) r_state <= S_FETCH;
    else        r_state <= w_next_state;
  end

  // Datapath registers: IR/operand latch, EXEC results, writeback and PC step.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_bus_en  <= 1'b0;
      r_pc      <= c_RESET_VEC;
      r_pc_next <= c_RESET_VEC + 32'd4;
      r_ir      <= 32'h0;
      r_a       <= 32'h0;
      r_b       <= 32'h0;
      r_alu     <= 32'h0;
      r_target  <= 32'h0;
      r_dst     <= 5'd0;
      r_wen     <= 1'b0;
      r_taken   <= 1'b0;
      for (int i = 0; i < 32; i++) r_gpr[i] <= 32'h0;
    end else begin
      r_bus_en <= 1'b1;
      case (r_state)
        S_DECODE: begin
          r_ir <= readdata;
          r_a  <= r_gpr[readdata[25:21]];
          r_b  <= r_gpr[readdata[20:16]];
        end
        S_EXEC: begin
          r_alu    <= w_alu;
          r_wen    <= w_wen;
          r_dst    <= w_dst;
          r_taken  <= w_taken;
          r_target <= w_target;
        end
        S_WB: begin
          if (r_wen && (r_dst != 5'd0))
            r_gpr[r_dst] <= w_is_lw ? readdata : r_alu;
          r_pc      <= r_pc_next;
          r_pc_next <= r_taken ? r_target : (r_pc_next + 32'd4);
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mips_cpu_bus.sv
`default_nettype none
// ============================================================================
// Module   : tb_mips_cpu_bus
// Purpose  : Self-checking bench for mips_cpu_bus with a wait-state RAM model
//            and a scoreboard of expected $v0 values and bus writes.
// Revision : 1.0  initial release
// ============================================================================
module tb_mips_cpu_bus;

  logic        clk = 1'b0;
  logic        reset;
  logic        active, write, read, waitrequest;
  logic [31:0] register_v0, address, writedata, readdata, check;
  logic [3:0]  byteenable;
  logic [2:0]  state_c;

  logic [31:0] rom  [0:63];
  logic [31:0] dram [0:63];
  int          wait_n = 0;
  int          r_cnt  = 0;

  int          vectors     = 0;
  int          miscompares = 0;
  logic [31:0] exp_q [$];
  logic [63:0] wr_q  [$];

  always #5 clk = ~clk;

  mips_cpu_bus u_dut (
    .clk(clk), .reset(reset), .active(active), .register_v0(register_v0),
    .address(address), .write(write), .read(read), .waitrequest(waitrequest),
    .writedata(writedata), .byteenable(byteenable), .readdata(readdata),
    .check(check), .state_c(state_c)
  );

  // RAM: stalls each request for wait_n cycles, read data valid next cycle.
  assign waitrequest = (read || write) && (r_cnt < wait_n);

  always @(posedge clk) begin
    if (!reset) begin
      r_cnt <= 0;
    end else if (read || write) begin
      if (waitrequest) begin
        r_cnt <= r_cnt + 1;
      end else begin
        r_cnt <= 0;
        if (read)
          readdata <= (address[31:20] == 12'hBFC) ? rom[address[7:2]] : dram[address[7:2]];
        if (write)
          dram[address[7:2]] <= writedata;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Bus protocol watcher: stability under stall, byteenable, write scoreboard.
  task automatic monitor();
    logic        stalled = 1'b0;
    logic [31:0] s_addr = '0, s_wd = '0;
    logic        s_rd = 1'b0, s_wr = 1'b0;
    logic [63:0] w;
    forever begin
      @(negedge clk);
      if (reset) begin
        if (stalled) begin
          chk("stall_addr", address, s_addr);
          chk("stall_req", {30'h0, read, write}, {30'h0, s_rd, s_wr});
          if (s_wr) chk("stall_wdata", writedata, s_wd);
        end
        if (read || write) begin
          chk("byteenable", {28'h0, byteenable}, 32'hF);
          chk("rd_wr_excl", {31'h0, read && write}, 32'h0);
        end
        if (write && !waitrequest) begin
          if (wr_q.size() == 0) begin
            chk("unexpected_write", {31'h0, write}, 32'h0);
          end else begin
            w = wr_q.pop_front();
            chk("wr_addr", address, w[63:32]);
            chk("wr_data", writedata, w[31:0]);
          end
        end
        stalled = (read || write) && waitrequest;
        s_addr  = address;
        s_wd    = writedata;
        s_rd    = read;
        s_wr    = write;
      end else begin
        stalled = 1'b0;
      end
    end
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 64; i++) rom[i] = 32'h0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_active", {31'h0, active}, 32'h1);
    chk("rst_read",   {31'h0, read},   32'h0);
    chk("rst_write",  {31'h0, write},  32'h0);
    chk("rst_state",  {29'h0, state_c}, 32'h0);
    chk("rst_ir",     check, 32'h0);
    chk("rst_v0",     register_v0, 32'h0);
    chk("rst_addr",   address, 32'hBFC0_0000);
    reset = 1'b1;
    @(negedge clk);
    chk("post_rst_active", {31'h0, active}, 32'h1);
  endtask

  task automatic run_to_halt(input string tag, input int budget);
    int n = 0;
    logic [31:0] e;
    while (active === 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_halt"}, {31'h0, active}, 32'h0);
    chk({tag, "_hstate"}, {29'h0, state_c}, 32'h7);
    chk({tag, "_hbus"}, {30'h0, read, write}, 32'h0);
    if (exp_q.size() == 0) begin
      chk({tag, "_noexp"}, 32'h1, {31'h0, active});
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_v0"}, register_v0, e);
    end
  endtask

  initial begin
    int n;
    reset  = 1'b0;
    wait_n = 0;
    clear_rom();
    fork monitor(); join_none

    // Basic ADDIU, then JR $0 with a NOP in its delay slot.
    clear_rom();
    rom[0] = 32'h2402_0005;   // ADDIU $2,$0,5
    rom[1] = 32'h0000_0008;   // JR $0
    rom[2] = 32'h0000_0000;   // NOP
    exp_q.push_back(32'd5);
    do_reset();
    run_to_halt("p1_addiu", 20);

    // Sign extension plus wraparound.
    clear_rom();
    rom[0] = 32'h2403_FFFF;   // ADDIU $3,$0,-1
    rom[1] = 32'h0063_1021;   // ADDU $2,$3,$3
    rom[2] = 32'h0000_0008;
    exp_q.push_back(32'hFFFF_FFFE);
    do_reset();
    run_to_halt("p2_wrap", 40);

    // Store then load with three wait states per request.
    clear_rom();
    rom[0] = 32'h3C03_1234;   // LUI $3,0x1234
    rom[1] = 32'h3463_5678;   // ORI $3,$3,0x5678
    rom[2] = 32'hAC03_0004;   // SW $3,4($0)
    rom[3] = 32'h8C02_0004;   // LW $2,4($0)
    rom[4] = 32'h0000_0008;
    wait_n = 3;
    wr_q.push_back({32'h0000_0004, 32'h1234_5678});
    exp_q.push_back(32'h1234_5678);
    do_reset();
    run_to_halt("p3_swlw", 200);
    chk("p3_wrq_empty", wr_q.size(), 32'h0);
    wait_n = 0;

    // Branch delay slot executes, skipped instruction does not.
    clear_rom();
    rom[0] = 32'h1000_0002;   // BEQ $0,$0,+2
    rom[1] = 32'h2442_0001;   // ADDIU $2,$2,1  (delay slot)
    rom[2] = 32'h2442_0010;   // ADDIU $2,$2,16 (skipped)
    rom[3] = 32'h0000_0008;
    exp_q.push_back(32'd1);
    do_reset();
    run_to_halt("p4_beq", 60);

    // Writes to $0 are discarded.
    clear_rom();
    rom[0] = 32'h2402_0009;   // ADDIU $2,$0,9
    rom[1] = 32'h2400_0007;   // ADDIU $0,$0,7
    rom[2] = 32'h0000_1021;   // ADDU $2,$0,$0
    rom[3] = 32'h0000_0008;
    exp_q.push_back(32'd0);
    do_reset();
    run_to_halt("p5_zero", 60);

    // Signed vs unsigned compare, shift, subtract: (1<<4) - 1 = 15.
    clear_rom();
    rom[0] = 32'h2403_FFFF;   // ADDIU $3,$0,-1
    rom[1] = 32'h0060_202A;   // SLT  $4,$3,$0  -> 1
    rom[2] = 32'h0003_282B;   // SLTU $5,$0,$3  -> 1
    rom[3] = 32'h0004_3100;   // SLL  $6,$4,4   -> 16
    rom[4] = 32'h00C5_1023;   // SUBU $2,$6,$5  -> 15
    rom[5] = 32'h0000_0008;
    exp_q.push_back(32'd15);
    do_reset();
    run_to_halt("p7_alu", 80);

    // Reset while a load is stalled, then a clean restart.
    clear_rom();
    rom[0] = 32'h8C02_0004;   // LW $2,4($0)
    rom[1] = 32'h0000_0008;
    wait_n = 5;
    do_reset();
    n = 0;
    while (!(state_c == 3'd3 && read && waitrequest) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("p6_stall_seen", {31'h0, state_c == 3'd3 && read && waitrequest}, 32'h1);
    reset = 1'b0;
    @(negedge clk);
    chk("p6_read",  {31'h0, read}, 32'h0);
    chk("p6_state", {29'h0, state_c}, 32'h0);
    chk("p6_addr",  address, 32'hBFC0_0000);
    reset  = 1'b1;
    wait_n = 0;
    exp_q.push_back(32'h1234_5678);
    run_to_halt("p6_restart", 40);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
